// File: rtl/sram_burst_master.sv
// rtl/sram_burst_master.sv - burst command master for a single-port synchronous SRAM
//
// Accepts one write or read burst command at a time. Each command carries a start
// address and a length of 1..16 beats. Write beats are streamed from the host to the
// SRAM, and read beats are streamed from the SRAM back to the host.
//
// Ports
//   i_clk, i_reset        clock; asynchronous active-high reset
//   i_cmd_*, o_cmd_ready  command handshake (we, start addr, len = beats-1)
//   i_wr_*, o_wr_ready    write beat handshake
//   o_rd_valid/data/last  read beat stream, no backpressure
//   o_busy                high whenever the FSM is not idle
//   o_wen/o_addr/o_w_data SRAM write enable, address and write data
//   i_read_data           SRAM read data, valid the cycle after the address

module sram_burst_master #(
    parameter int DW = 8,
    parameter int AW = 8
) (
    input  logic          i_clk,
    input  logic          i_reset,
    input  logic          i_cmd_valid,
    output logic          o_cmd_ready,
    input  logic          i_cmd_we,
    input  logic [AW-1:0] i_cmd_addr,
    input  logic [3:0]    i_cmd_len,
    input  logic          i_wr_valid,
    output logic          o_wr_ready,
    input  logic [DW-1:0] i_wr_data,
    output logic          o_rd_valid,
    output logic [DW-1:0] o_rd_data,
    output logic          o_rd_last,
    output logic          o_busy,
    output logic          o_wen,
    output logic [AW-1:0] o_addr,
    output logic [DW-1:0] o_w_data,
    input  logic [DW-1:0] i_read_data
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_WRITE = 2'd1,
        S_READ  = 2'd2,
        S_DRAIN = 2'd3
    } state_t;

    state_t        r_state;
    logic [AW-1:0] r_addr;
    logic [3:0]    r_len;
    logic [3:0]    r_cnt;
    logic          r_rd_valid;
    logic          r_rd_last;

    logic          w_last_beat;
    logic          w_wen;

    assign w_last_beat = (r_cnt == r_len);

    // The write enable is combinational from the FSM state. The asynchronous reset
    // forces r_state to IDLE, so a write in flight is stopped without waiting for
    // a clock edge.
    assign w_wen = (r_state == S_WRITE) && i_wr_valid;

    assign o_wen       = w_wen;
    assign o_w_data    = w_wen ? i_wr_data : '0;
    assign o_addr      = r_addr;
    assign o_cmd_ready = (r_state == S_IDLE);
    assign o_wr_ready  = (r_state == S_WRITE);
    assign o_busy      = (r_state != S_IDLE);
    assign o_rd_valid  = r_rd_valid;
    assign o_rd_last   = r_rd_last;
    // The SRAM presents its data one cycle after the address, which is the cycle in
    // which r_rd_valid is high. Because of this the read data is passed straight through.
    assign o_rd_data   = i_read_data;

    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            r_state    <= S_IDLE;
            r_addr     <= '0;
            r_len      <= '0;
            r_cnt      <= '0;
            r_rd_valid <= 1'b0;
            r_rd_last  <= 1'b0;
        end else begin
            r_rd_valid <= 1'b0;
            r_rd_last  <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (i_cmd_valid) begin
                        r_addr  <= i_cmd_addr;
                        r_len   <= i_cmd_len;
                        r_cnt   <= '0;
                        r_state <= i_cmd_we ? S_WRITE : S_READ;
                    end
                end
                S_WRITE: begin
                    // Stall with address and count held until the host offers a beat.
                    if (i_wr_valid) begin
                        r_addr <= r_addr + AW'(1);
                        if (w_last_beat) begin
                            r_cnt   <= '0;
                            r_state <= S_IDLE;
                        end else begin
                            r_cnt <= r_cnt + 4'd1;
                        end
                    end
                end
                S_READ: begin
                    // One read is issued every cycle. The matching beat is flagged
                    // for the next cycle.
                    r_rd_valid <= 1'b1;
                    r_rd_last  <= w_last_beat;
                    r_addr     <= r_addr + AW'(1);
                    if (w_last_beat) begin
                        r_cnt   <= '0;
                        r_state <= S_DRAIN;
                    end else begin
                        r_cnt <= r_cnt + 4'd1;
                    end
                end
                S_DRAIN: begin
                    // The final read beat is on the outputs during this cycle.
                    r_state <= S_IDLE;
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_sram_burst_master.sv
// tb/tb_sram_burst_master.sv - table-driven bench for sram_burst_master with an SRAM model

module tb_sram_burst_master;

    logic       clk = 1'b0;
    logic       reset;
    logic       cmd_valid, cmd_ready, cmd_we;
    logic [7:0] cmd_addr;
    logic [3:0] cmd_len;
    logic       wr_valid, wr_ready;
    logic [7:0] wr_data;
    logic       rd_valid, rd_last, busy, wen;
    logic [7:0] rd_data, addr, w_data;
    logic [7:0] read_data;

    logic [7:0] mem [256];
    int         wen_cnt = 0;
    int         checks = 0;
    int         failures = 0;

    always #5 clk = ~clk;

    sram_burst_master #(.DW(8), .AW(8)) dut (
        .i_clk       (clk),
        .i_reset     (reset),
        .i_cmd_valid (cmd_valid),
        .o_cmd_ready (cmd_ready),
        .i_cmd_we    (cmd_we),
        .i_cmd_addr  (cmd_addr),
        .i_cmd_len   (cmd_len),
        .i_wr_valid  (wr_valid),
        .o_wr_ready  (wr_ready),
        .i_wr_data   (wr_data),
        .o_rd_valid  (rd_valid),
        .o_rd_data   (rd_data),
        .o_rd_last   (rd_last),
        .o_busy      (busy),
        .o_wen       (wen),
        .o_addr      (addr),
        .o_w_data    (w_data),
        .i_read_data (read_data)
    );

    // Synchronous SRAM: write on the edge where wen=1, read data one cycle after the address.
    always @(posedge clk) begin
        if (wen) mem[addr] <= w_data;
        read_data <= mem[addr];
        if (wen) wen_cnt <= wen_cnt + 1;
    end

    typedef struct {
        bit               we;
        logic [7:0]       a;
        logic [3:0]       len;
        logic [3:0][7:0]  d;    // write data, or expected read data, beat i in d[i]
    } vec_t;

    vec_t tbl [7];

    function automatic vec_t mk(bit we, logic [7:0] a, logic [3:0] len,
                                logic [7:0] b0, logic [7:0] b1, logic [7:0] b2, logic [7:0] b3);
        vec_t v;
        v.we  = we;
        v.a   = a;
        v.len = len;
        v.d   = {b3, b2, b1, b0};
        return v;
    endfunction

    task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send_cmd(bit we, logic [7:0] a, logic [3:0] len, string tag);
        cmd_valid = 1'b1;
        cmd_we    = we;
        cmd_addr  = a;
        cmd_len   = len;
        #1;
        chk({tag, "_cmd_ready"}, cmd_ready, 1);
        chk({tag, "_idle_busy"}, busy, 0);
        tick();
        cmd_valid = 1'b0;
    endtask

    task automatic do_write(vec_t v, int gap, string tag);
        int start_cnt;
        start_cnt = wen_cnt;
        send_cmd(1'b1, v.a, v.len, tag);
        for (int i = 0; i <= int'(v.len); i++) begin
            if (i == 1) begin
                for (int g = 0; g < gap; g++) begin
                    wr_valid = 1'b0;
                    #1;
                    chk($sformatf("%s_gap%0d_wen", tag, g), wen, 0);
                    chk($sformatf("%s_gap%0d_addr", tag, g), addr, 8'(v.a + 8'd1));
                    chk($sformatf("%s_gap%0d_wr_ready", tag, g), wr_ready, 1);
                    tick();
                end
            end
            wr_valid = 1'b1;
            wr_data  = v.d[i];
            #1;
            chk($sformatf("%s_b%0d_wen", tag, i), wen, 1);
            chk($sformatf("%s_b%0d_addr", tag, i), addr, 8'(v.a + 8'(i)));
            chk($sformatf("%s_b%0d_wdata", tag, i), w_data, v.d[i]);
            tick();
        end
        wr_valid = 1'b0;
        #1;
        chk({tag, "_end_busy"}, busy, 0);
        chk({tag, "_end_wen"}, wen, 0);
        chk({tag, "_wen_count"}, wen_cnt - start_cnt, int'(v.len) + 1);
    endtask

    task automatic do_read(vec_t v, bit poke, string tag);
        int start_cnt;
        start_cnt = wen_cnt;
        send_cmd(1'b0, v.a, v.len, tag);
        for (int k = 0; k <= int'(v.len); k++) begin
            if (poke && k >= 1) begin
                cmd_valid = 1'b1;
                cmd_we    = 1'b1;
                cmd_addr  = 8'h50;
                cmd_len   = 4'd0;
            end
            #1;
            chk($sformatf("%s_r%0d_addr", tag, k), addr, 8'(v.a + 8'(k)));
            chk($sformatf("%s_r%0d_wen", tag, k), wen, 0);
            chk($sformatf("%s_r%0d_rd_valid", tag, k), rd_valid, (k > 0) ? 1 : 0);
            if (k > 0) begin
                chk($sformatf("%s_r%0d_rd_data", tag, k), rd_data, v.d[k-1]);
                chk($sformatf("%s_r%0d_rd_last", tag, k), rd_last, 0);
            end
            if (poke && k >= 1) chk($sformatf("%s_r%0d_cmd_ready", tag, k), cmd_ready, 0);
            tick();
        end
        cmd_valid = 1'b0;
        #1;
        chk({tag, "_drain_rd_valid"}, rd_valid, 1);
        chk({tag, "_drain_rd_last"}, rd_last, 1);
        chk({tag, "_drain_rd_data"}, rd_data, v.d[v.len]);
        chk({tag, "_drain_busy"}, busy, 1);
        tick();
        chk({tag, "_end_busy"}, busy, 0);
        chk({tag, "_end_rd_valid"}, rd_valid, 0);
        if (poke) begin
            tick();
            chk({tag, "_not_queued_busy"}, busy, 0);
            chk({tag, "_no_extra_wen"}, wen_cnt - start_cnt, 0);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1);
    end

    initial begin
        int base;
        for (int i = 0; i < 256; i++) mem[i] = 8'h00;
        reset = 1'b1; cmd_valid = 1'b0; cmd_we = 1'b0; cmd_addr = 8'h00; cmd_len = 4'd0;
        wr_valid = 1'b0; wr_data = 8'h00;

        tbl[0] = mk(1'b1, 8'h03, 4'd3, 8'h87, 8'h24, 8'h38, 8'h05);
        tbl[1] = mk(1'b0, 8'h03, 4'd3, 8'h87, 8'h24, 8'h38, 8'h05);
        tbl[2] = mk(1'b1, 8'hFE, 4'd2, 8'h11, 8'h22, 8'h33, 8'h00);
        tbl[3] = mk(1'b0, 8'hFE, 4'd2, 8'h11, 8'h22, 8'h33, 8'h00);
        tbl[4] = mk(1'b1, 8'h40, 4'd0, 8'hA5, 8'h00, 8'h00, 8'h00);
        tbl[5] = mk(1'b0, 8'h40, 4'd0, 8'hA5, 8'h00, 8'h00, 8'h00);
        tbl[6] = mk(1'b1, 8'h20, 4'd3, 8'h01, 8'h02, 8'h03, 8'h04);

        // Reset state, with a command and a write beat offered during reset
        tick();
        cmd_valid = 1'b1; cmd_we = 1'b1; cmd_addr = 8'h77; wr_valid = 1'b1; wr_data = 8'hFF;
        #1;
        chk("rst_wen", wen, 0);
        chk("rst_addr", addr, 0);
        chk("rst_w_data", w_data, 0);
        chk("rst_busy", busy, 0);
        chk("rst_wr_ready", wr_ready, 0);
        chk("rst_rd_valid", rd_valid, 0);
        chk("rst_rd_last", rd_last, 0);
        tick();
        chk("rst_cmd_not_taken", busy, 0);
        cmd_valid = 1'b0;
        reset = 1'b0;
        #1;
        chk("idle_wr_valid_wen", wen, 0);
        chk("idle_wr_ready", wr_ready, 0);
        tick();
        wr_valid = 1'b0;
        chk("idle_busy", busy, 0);

        for (int i = 0; i < 7; i++) begin
            if (tbl[i].we) do_write(tbl[i], 0, $sformatf("v%0d_wr", i));
            else           do_read(tbl[i], 1'b0, $sformatf("v%0d_rd", i));
        end

        // Stall between two beats, then read back
        do_write(mk(1'b1, 8'h80, 4'd1, 8'hC1, 8'hC2, 8'h00, 8'h00), 3, "stall_wr");
        do_read(mk(1'b0, 8'h80, 4'd1, 8'hC1, 8'hC2, 8'h00, 8'h00), 1'b0, "stall_rd");

        // Command offered during a read burst is ignored
        do_read(tbl[1], 1'b1, "busy_cmd");

        // Reset after 2 of 4 beats of a write to 0x20 (previously 01..04)
        base = wen_cnt;
        send_cmd(1'b1, 8'h20, 4'd3, "rstmid");
        wr_valid = 1'b1; wr_data = 8'hE1; tick();
        wr_data = 8'hE2; tick();
        wr_data = 8'hE3;
        #1;
        chk("rstmid_pre_wen", wen, 1);
        reset = 1'b1;
        #1;
        chk("rstmid_wen", wen, 0);
        chk("rstmid_busy", busy, 0);
        chk("rstmid_addr", addr, 0);
        chk("rstmid_wr_ready", wr_ready, 0);
        tick();
        tick();
        wr_valid = 1'b0;
        reset = 1'b0;
        #1;
        chk("rstmid_release_busy", busy, 0);
        chk("rstmid_release_rd_valid", rd_valid, 0);
        chk("rstmid_wen_count", wen_cnt - base, 2);
        tick();
        do_read(mk(1'b0, 8'h20, 4'd3, 8'hE1, 8'hE2, 8'h03, 8'h04), 1'b0, "rstmid_rd");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/sram_burst_master.md
SRAM_BURST_MASTER -- requirements
Module: sram_burst_master

Interface
REQ-001 Parameter DW, default 8, SRAM data width in bits.
REQ-002 Parameter AW, default 8, SRAM address width in bits.
REQ-003 clk  in  1  single clock for the whole block; all state updates on rising edge.
REQ-004 reset  in  1  asynchronous, active-high reset.
REQ-005 cmd_valid  in  1  host command offered.
REQ-006 cmd_ready  out  1  block accepts a command this cycle (high only in IDLE).
REQ-007 cmd_we  in  1  1 = write burst, 0 = read burst.
REQ-008 cmd_addr  in  AW  burst start address.
REQ-009 cmd_len  in  4  burst length minus one (beats = cmd_len+1, 1..16).
REQ-010 wr_valid  in  1  host write beat offered.
REQ-011 wr_ready  out  1  block accepts a write beat this cycle.
REQ-012 wr_data  in  DW  write beat data.
REQ-013 rd_valid  out  1  one-cycle pulse, rd_data holds a read beat; no backpressure.
REQ-014 rd_data  out  DW  read beat data.
REQ-015 rd_last  out  1  qualifies the final read beat of a burst.
REQ-016 busy  out  1  high whenever state is not IDLE.
REQ-017 wen  out  1  SRAM write enable; SRAM writes w_data to addr on the rising edge where wen=1.
REQ-018 addr  out  AW  SRAM address.
REQ-019 w_data  out  DW  SRAM write data.
REQ-020 read_data  in  DW  SRAM read data, valid the cycle after addr is presented with wen=0.

Function
REQ-021 The block SHALL implement states IDLE, WRITE, READ, DRAIN.
REQ-022 A command SHALL be accepted on an edge where cmd_valid=1, cmd_ready=1 and reset=0; start address, length and direction are latched; next state is WRITE (cmd_we=1) or READ (cmd_we=0).
REQ-023 cmd_ready SHALL be 1 only in IDLE; commands offered while busy are ignored and not queued.
REQ-024 In WRITE, wr_ready SHALL be 1; on each cycle with wr_valid=1, wen=1, addr=current address, w_data=wr_data combinationally, and the address and beat count advance at the edge.
REQ-025 In WRITE with wr_valid=0, wen SHALL be 0 and address/count hold (stall, no timeout).
REQ-026 After beat cmd_len+1 is written, the next state SHALL be IDLE.
REQ-027 In READ, the block SHALL issue one read per cycle (wen=0, addr=current address), advancing the address each cycle, for cmd_len+1 consecutive cycles, then enter DRAIN.
REQ-028 rd_valid SHALL pulse exactly one cycle after each read issue, with rd_data=read_data; rd_last=1 only with the final beat.
REQ-029 DRAIN SHALL last one cycle (final rd_valid/rd_last beat), then go to IDLE.
REQ-030 Address increment SHALL be modulo 2^AW (0xFF -> 0x00 for AW=8), with no error flag.
REQ-031 In IDLE and DRAIN, wen=0, wr_ready=0; addr holds its last value.
REQ-032 wr_valid outside WRITE SHALL have no effect; write beats are never buffered.

Reset
REQ-033 While reset=1: state=IDLE, wen=0, addr=0, w_data=0, rd_valid=0, rd_last=0, busy=0, wr_ready=0, beat counter=0; cmd_ready may be 1 but no command is accepted.
REQ-034 Reset asserted mid-burst SHALL abort it immediately: wen drops to 0 asynchronously, no pending rd_valid is emitted, and after release the block is in IDLE with no residue from the aborted burst.

Verification
REQ-035 Write burst: cmd_we=1, addr=0x03, len=3, wr_data 0x87,0x24,0x38,0x05 back-to-back -> wen=1 for 4 cycles at addr 0x03,0x04,0x05,0x06 with those data; busy falls the cycle after the 4th beat.
REQ-036 Read-back: cmd_we=0, addr=0x03, len=3 -> 4 rd_valid pulses on consecutive cycles, data 0x87,0x24,0x38,0x05, rd_last on the 4th only, then IDLE.
REQ-037 Wrap: write addr=0xFE, len=2, data 0x11,0x22,0x33 -> SRAM addr 0xFE,0xFF,0x00; read back returns the same three values.
REQ-038 Stall: write len=1 with wr_valid low for 3 cycles between beats -> exactly 2 wen pulses, wen=0 and addr held during the gap.
REQ-039 Busy command: second cmd_valid during a read burst -> cmd_ready=0, command ignored, no extra SRAM access.
REQ-040 Reset mid-write: assert reset after 2 of 4 beats -> wen=0 immediately, busy=0; a new read from the start address returns the 2 written bytes and the old contents of the remaining addresses.
